slave_port: RTL and testbench
=============================

Name: slave_port

Overview:
- Responder end of the serial master/slave bus protocol.
- Sits behind master_mux/slave_mux and deserialises address, burst length and write data driven by a master port.
- Owns a local word memory and serialises read data back to the granted master under a master_ready/slave_valid handshake.
- Reports completion with a one-cycle done pulse.

Parameters:
ADDR_WIDTH, 12, serial address length in bits; memory depth is 2**ADDR_WIDTH words
DATA_WIDTH, 8, word width in bits
BURST_WIDTH, 4, serial burst field length; words per transfer = burst value + 1

Ports:
clk  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
read_en  input  1  read request from the master mux
write_en  input  1  write request from the master mux
master_valid  input  1  master drives a valid serial bit this cycle
master_ready  input  1  master accepts the current tx_data bit this cycle
rx_address  input  1  serial address, MSB first
rx_burst  input  1  serial burst count, MSB first
rx_data  input  1  serial write data, MSB first per word
rx_done_in  input  1  master terminates the transaction (abort)
slave_ready  output  1  slave accepts serial bits (IDLE/ADDR/BURST/WDATA)
slave_valid  output  1  tx_data carries a valid read bit
tx_data  output  1  serial read data, MSB first; 0 whenever slave_valid=0
slave_tx_done  output  1  one-cycle pulse on transaction completion

Behaviour:
- Reset (synchronous, wins over everything, also mid-transfer):
  - state=IDLE; all counters and shift registers cleared.
  - Outputs after reset: slave_ready=1, slave_valid=0, tx_data=0, slave_tx_done=0.
  - Memory contents are not cleared.
- States: IDLE, ADDR, BURST, WDATA, RLOAD, RDATA, DONE.
- "Sample" means: on a rising edge with master_valid=1, shift one bit in from the relevant serial input. If master_valid=0, nothing is shifted and the state holds.
- IDLE:
  - Accept condition: master_valid=1 and exactly one of read_en/write_en is 1.
  - On accept, latch the op and sample address bit [ADDR_WIDTH-1] in that same cycle, then go to ADDR (or to BURST if ADDR_WIDTH=1).
  - read_en=write_en (both 0 or both 1) with master_valid=1: ignore and stay in IDLE.
- ADDR: sample rx_address until ADDR_WIDTH bits total are held, then go to BURST.
- BURST: sample rx_burst BURST_WIDTH bits; value b gives b+1 words (1..2**BURST_WIDTH). On the last bit, go to WDATA (write) or RLOAD (read).
- WDATA:
  - Sample rx_data. On the edge that samples bit 0 of a word, write mem[addr] and set addr = (addr+1) mod 2**ADDR_WIDTH.
  - After word b+1, go to DONE.
- RLOAD:
  - One cycle with slave_valid=0; a synchronous memory read of mem[addr] is issued.
  - On the next edge, the word loads into the tx shift register, addr increments (wrapping), and the state goes to RDATA.
  - First valid bit is visible 2 cycles after the edge that sampled the last burst bit.
- RDATA:
  - slave_valid=1 and tx_data = shift-register MSB.
  - The bit advances only on an edge with master_ready=1; with master_ready=0 the bit holds indefinitely.
  - After the LSB of a word is accepted: go to RLOAD if words remain (one bubble cycle per word), otherwise DONE.
- DONE: slave_tx_done=1, slave_ready=0, slave_valid=0 for exactly one cycle, then IDLE.
- Abort: rx_done_in=1 in any state other than IDLE/DONE returns to IDLE on the next edge.
  - No slave_tx_done pulse.
  - Fully received write words stay committed; a partial word is discarded.
- Address wrap: bursts crossing the top address continue from 0.
- Simultaneous events: reset beats rx_done_in; rx_done_in beats master_valid/master_ready sampling in the same cycle.
- slave_ready is decoded from state: 1 in IDLE/ADDR/BURST/WDATA, 0 in RLOAD/RDATA/DONE.

Test Plan:
1. Assert reset for 2 cycles during an active WDATA -> IDLE next cycle; slave_ready=1, slave_valid=0, tx_data=0, slave_tx_done=0; words written before reset still read back.
2. Write addr 0x005, b=0, data 0xA5 -> slave_tx_done pulses 1 cycle after the data LSB. Then read 0x005, b=0 with master_ready=1 -> tx_data 1,0,1,0,0,1,0,1 on consecutive cycles, slave_tx_done after the last bit.
3. Write addr 0xFFE, b=3, data 0x11,0x22,0x33,0x44 -> mem[0xFFE]=0x11, [0xFFF]=0x22, [0x000]=0x33, [0x001]=0x44. Reading 0xFFE with b=3 returns the same order, with one slave_valid=0 bubble between words.
4. Read 0x005 with master_ready alternating 1/0 -> each tx_data bit held while master_ready=0; 8 bits complete in 16 RDATA cycles.
5. Insert master_valid=0 gaps mid-address, and issue read_en=write_en=1 in IDLE -> gaps add no bits (address decodes correctly); the illegal request leaves the block in IDLE with slave_ready=1.
6. Read b=1 and assert rx_done_in after 3 bits -> IDLE next cycle, slave_valid=0, no slave_tx_done. Write b=2 aborted after 2 words -> first 2 words committed, third address unchanged.

Source files
------------

// File: rtl/slave_port.sv
// Serial bus responder: deserialises address, burst length and write data
// from a master port, owns a local word memory, and serialises read data
// back under a master_ready/slave_valid handshake.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a single read or write request with a valid bit
// ADDR   | shifting in the remaining address bits, MSB first
// BURST  | shifting in the burst length (words = value + 1)
// WDATA  | shifting in write words; each full word is committed
// RLOAD  | bubble cycle: memory word fetched into the tx shifter
// RDATA  | presenting read bits, advancing on master_ready
// DONE   | one-cycle completion pulse
module slave_port #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 8,
  parameter int BURST_WIDTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic read_en,
  input  logic write_en,
  input  logic master_valid,
  input  logic master_ready,
  input  logic rx_address,
  input  logic rx_burst,
  input  logic rx_data,
  input  logic rx_done_in,
  output logic slave_ready,
  output logic slave_valid,
  output logic tx_data,
  output logic slave_tx_done
);

  localparam int MAX_AD = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int MAX_W  = (MAX_AD > BURST_WIDTH) ? MAX_AD : BURST_WIDTH;
  localparam int CNT_W  = $clog2(MAX_W + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_BURST, S_WDATA, S_RLOAD, S_RDATA, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic                   op_write;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [BURST_WIDTH-1:0] burst;
  logic [BURST_WIDTH-1:0] word_cnt;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_WIDTH-1:0]  wdata_sr;
  logic [DATA_WIDTH-1:0]  tx_sr;
  logic [DATA_WIDTH-1:0]  mem [2**ADDR_WIDTH];

  logic                   accept;
  logic                   abort;
  logic                   bit_last;
  logic                   word_last;
  logic                   mem_we;
  logic [DATA_WIDTH-1:0]  wdata_word;
  logic [BURST_WIDTH-1:0] burst_word;

  // Shared decode of request, abort and counter terminal counts
  always_comb begin
    accept     = master_valid && (read_en ^ write_en);
    abort      = rx_done_in && (state != S_IDLE) && (state != S_DONE);
    bit_last   = (bit_cnt == '0);
    word_last  = (word_cnt == '0);
    wdata_word = (wdata_sr << 1) | DATA_WIDTH'(rx_data);
    burst_word = (burst << 1) | BURST_WIDTH'(rx_burst);
    // Abort beats the sampling of the final bit, so a partial word never lands
    mem_we     = (state == S_WDATA) && master_valid && bit_last && !abort && !reset;
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_nxt     = state;
    slave_ready   = 1'b0;
    slave_valid   = 1'b0;
    tx_data       = 1'b0;
    slave_tx_done = 1'b0;
    case (state)
      S_IDLE: begin
        slave_ready = 1'b1;
        if (accept) state_nxt = (ADDR_WIDTH == 1) ? S_BURST : S_ADDR;
      end
      S_ADDR: begin
        slave_ready = 1'b1;
        if (master_valid && bit_last) state_nxt = S_BURST;
      end
      S_BURST: begin
        slave_ready = 1'b1;
        if (master_valid && bit_last) state_nxt = op_write ? S_WDATA : S_RLOAD;
      end
      S_WDATA: begin
        slave_ready = 1'b1;
        if (master_valid && bit_last && word_last) state_nxt = S_DONE;
      end
      S_RLOAD: state_nxt = S_RDATA;
      S_RDATA: begin
        slave_valid = 1'b1;
        tx_data     = tx_sr[DATA_WIDTH-1];
        if (master_ready && bit_last) state_nxt = word_last ? S_DONE : S_RLOAD;
      end
      S_DONE: begin
        slave_tx_done = 1'b1;
        state_nxt     = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Address/burst/data shifters and down-counters; frozen on abort
  always_ff @(posedge clk) begin
    if (reset) begin
      op_write <= 1'b0;
      addr     <= '0;
      burst    <= '0;
      word_cnt <= '0;
      bit_cnt  <= '0;
      wdata_sr <= '0;
      tx_sr    <= '0;
    end else if (!abort) begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_write <= write_en;
            addr     <= ADDR_WIDTH'(rx_address);
            bit_cnt  <= (ADDR_WIDTH == 1) ? CNT_W'(BURST_WIDTH - 1) : CNT_W'(ADDR_WIDTH - 2);
          end
        end
        S_ADDR: begin
          if (master_valid) begin
            addr    <= (addr << 1) | ADDR_WIDTH'(rx_address);
            bit_cnt <= bit_last ? CNT_W'(BURST_WIDTH - 1) : bit_cnt - 1'b1;
          end
        end
        S_BURST: begin
          if (master_valid) begin
            burst <= burst_word;
            if (bit_last) begin
              word_cnt <= burst_word;
              bit_cnt  <= CNT_W'(DATA_WIDTH - 1);
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
        end
        S_WDATA: begin
          if (master_valid) begin
            wdata_sr <= wdata_word;
            if (bit_last) begin
              addr     <= addr + 1'b1;
              bit_cnt  <= CNT_W'(DATA_WIDTH - 1);
              word_cnt <= word_cnt - 1'b1;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
        end
        S_RLOAD: begin
          tx_sr   <= mem[addr];
          addr    <= addr + 1'b1;
          bit_cnt <= CNT_W'(DATA_WIDTH - 1);
        end
        S_RDATA: begin
          if (master_ready) begin
            tx_sr <= tx_sr << 1;
            if (bit_last) begin
              bit_cnt  <= CNT_W'(DATA_WIDTH - 1);
              word_cnt <= word_cnt - 1'b1;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Word memory; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr] <= wdata_word;
  end

endmodule

// File: tb/tb_slave_port.sv
// Bench for slave_port: drives serial transactions with random gaps and
// handshake patterns, and checks read-back against a flat memory model.
module tb_slave_port;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic reset, read_en, write_en, master_valid, master_ready;
  logic rx_address, rx_burst, rx_data, rx_done_in;
  logic slave_ready, slave_valid, tx_data, slave_tx_done;

  int cmp_count = 0;
  int err_count = 0;

  logic [DW-1:0] ref_mem [2**AW];
  logic [DW-1:0] wr_q [$];
  logic [DW-1:0] rd_q [$];
  int rd_invalid, rd_rdata, rd_held_bad;
  bit rd_done_seen;

  always #5 clk = ~clk;

  slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW)) dut (
    .clk(clk), .reset(reset), .read_en(read_en), .write_en(write_en),
    .master_valid(master_valid), .master_ready(master_ready),
    .rx_address(rx_address), .rx_burst(rx_burst), .rx_data(rx_data),
    .rx_done_in(rx_done_in), .slave_ready(slave_ready), .slave_valid(slave_valid),
    .tx_data(tx_data), .slave_tx_done(slave_tx_done)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    read_en = 0; write_en = 0; master_valid = 0; master_ready = 0;
    rx_address = 1'($urandom); rx_burst = 1'($urandom); rx_data = 1'($urandom);
    rx_done_in = 0;
  endtask

  // One serial bit on line 0=address, 1=burst, 2=data, preceded by random idle gaps
  task automatic put_bit(input int line, input logic v, input int gap_pct,
                         input logic rd, input logic wr);
    while (int'($urandom_range(99)) < gap_pct) begin
      master_valid = 0; read_en = rd; write_en = wr;
      rx_address = 1'($urandom); rx_burst = 1'($urandom); rx_data = 1'($urandom);
      cyc();
    end
    master_valid = 1; read_en = rd; write_en = wr;
    rx_address = 1'($urandom); rx_burst = 1'($urandom); rx_data = 1'($urandom);
    case (line)
      0: rx_address = v;
      1: rx_burst = v;
      default: rx_data = v;
    endcase
    cyc();
    master_valid = 0; read_en = 0; write_en = 0;
  endtask

  task automatic send_header(input logic wr, input logic [AW-1:0] a,
                             input logic [BW-1:0] b, input int gap);
    for (int i = AW - 1; i >= 0; i--)
      put_bit(0, a[i], gap, (i == AW - 1) && !wr, (i == AW - 1) && wr);
    for (int i = BW - 1; i >= 0; i--) put_bit(1, b[i], gap, 1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [DW-1:0] d, input int nbits, input int gap);
    for (int i = DW - 1; i >= DW - nbits; i--) put_bit(2, d[i], gap, 1'b0, 1'b0);
  endtask

  // Full write from wr_q; returns #1 after the edge that samples the final data bit
  task automatic do_write(input logic [AW-1:0] a, input logic [BW-1:0] b, input int gap);
    send_header(1'b1, a, b, gap);
    for (int w = 0; w <= int'(b); w++) begin
      send_word(wr_q[w], DW, gap);
      ref_mem[AW'(int'(a) + w)] = wr_q[w];
    end
  endtask

  // Full read; mode 0: ready always, 1: ready alternating 0/1, 2: random ready
  task automatic do_read(input logic [AW-1:0] a, input logic [BW-1:0] b,
                         input int gap, input int mode);
    logic [DW-1:0] cur;
    logic r, prev_valid, prev_ready, prev_bit;
    int nbits;
    send_header(1'b0, a, b, gap);
    rd_q.delete();
    rd_invalid = 0; rd_rdata = 0; rd_held_bad = 0; rd_done_seen = 0;
    prev_valid = 0; prev_ready = 0; prev_bit = 0; nbits = 0; cur = '0;
    for (int c = 0; c < 3000; c++) begin
      if (slave_tx_done) begin
        rd_done_seen = 1;
        master_ready = 0;
        cyc();
        break;
      end
      if (!slave_valid) begin
        rd_invalid++;
      end else begin
        if (prev_valid && !prev_ready && tx_data !== prev_bit) rd_held_bad++;
        case (mode)
          0: r = 1'b1;
          1: r = rd_rdata[0];
          default: r = 1'($urandom);
        endcase
        master_ready = r;
        rd_rdata++;
        if (r) begin
          cur = {cur[DW-2:0], tx_data};
          nbits++;
          if (nbits == DW) begin rd_q.push_back(cur); nbits = 0; end
        end
      end
      prev_valid = slave_valid; prev_ready = master_ready; prev_bit = tx_data;
      cyc();
      master_ready = 1'($urandom);
    end
    master_ready = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs();
    cyc(); cyc();
    cmp_count++; if (slave_ready !== 1'b1) begin err_count++; $display("FAIL reset_ready got %b want 1", slave_ready); end
    cmp_count++; if (slave_valid !== 1'b0) begin err_count++; $display("FAIL reset_valid got %b want 0", slave_valid); end
    cmp_count++; if (tx_data !== 1'b0) begin err_count++; $display("FAIL reset_tx got %b want 0", tx_data); end
    cmp_count++; if (slave_tx_done !== 1'b0) begin err_count++; $display("FAIL reset_done got %b want 0", slave_tx_done); end
    reset = 0;
    cyc();
  endtask

  task automatic test_single();
    wr_q = '{8'hA5};
    do_write(12'h005, 4'd0, 0);
    cmp_count++; if (slave_tx_done !== 1'b1 || slave_ready !== 1'b0) begin err_count++; $display("FAIL single_wr_done got done=%b ready=%b want 1/0", slave_tx_done, slave_ready); end
    cyc();
    cmp_count++; if (slave_tx_done !== 1'b0 || slave_ready !== 1'b1) begin err_count++; $display("FAIL single_wr_idle got done=%b ready=%b want 0/1", slave_tx_done, slave_ready); end
    do_read(12'h005, 4'd0, 0, 0);
    cmp_count++; if (rd_q.size() != 1 || rd_q[0] !== 8'hA5) begin err_count++; $display("FAIL single_rd_data got n=%0d d=%h want 1 a5", rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : 8'hxx); end
    cmp_count++; if (rd_rdata != 8 || rd_invalid != 1 || !rd_done_seen) begin err_count++; $display("FAIL single_rd_timing got rdata=%0d bubbles=%0d done=%0d want 8 1 1", rd_rdata, rd_invalid, rd_done_seen); end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] exp_w [4];
    exp_w = '{8'h11, 8'h22, 8'h33, 8'h44};
    wr_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_write(12'hFFE, 4'd3, 0);
    cmp_count++; if (slave_tx_done !== 1'b1) begin err_count++; $display("FAIL wrap_wr_done got %b want 1", slave_tx_done); end
    cyc();
    do_read(12'hFFE, 4'd3, 0, 0);
    for (int w = 0; w < 4; w++) begin
      cmp_count++;
      if (w >= rd_q.size() || rd_q[w] !== exp_w[w]) begin err_count++; $display("FAIL wrap_word%0d got %h want %h", w, (w < rd_q.size()) ? rd_q[w] : 8'hxx, exp_w[w]); end
    end
    cmp_count++; if (rd_invalid != 4 || rd_rdata != 32 || !rd_done_seen) begin err_count++; $display("FAIL wrap_timing got bubbles=%0d rdata=%0d done=%0d want 4 32 1", rd_invalid, rd_rdata, rd_done_seen); end
    do_read(12'hFFF, 4'd1, 0, 0);
    cmp_count++; if (rd_q.size() != 2 || rd_q[0] !== 8'h22 || rd_q[1] !== 8'h33) begin err_count++; $display("FAIL wrap_top got n=%0d want 22 33", rd_q.size()); end
  endtask

  task automatic test_ready_stall();
    do_read(12'h005, 4'd0, 0, 1);
    cmp_count++; if (rd_q.size() != 1 || rd_q[0] !== 8'hA5) begin err_count++; $display("FAIL stall_data got n=%0d want a5", rd_q.size()); end
    cmp_count++; if (rd_rdata != 16 || rd_held_bad != 0 || !rd_done_seen) begin err_count++; $display("FAIL stall_timing got rdata=%0d held_bad=%0d done=%0d want 16 0 1", rd_rdata, rd_held_bad, rd_done_seen); end
  endtask

  task automatic test_gaps_illegal();
    for (int i = 0; i < 6; i++) begin
      read_en = (i < 4); write_en = (i < 4); master_valid = 1;
      rx_address = 1'($urandom); rx_burst = 1'($urandom); rx_data = 1'($urandom);
      cyc();
      cmp_count++; if (slave_ready !== 1'b1 || slave_valid !== 1'b0) begin err_count++; $display("FAIL illegal_idle cyc%0d got ready=%b valid=%b want 1/0", i, slave_ready, slave_valid); end
    end
    idle_inputs();
    wr_q = '{8'h5A};
    do_write(12'h2C7, 4'd0, 40);
    cmp_count++; if (slave_tx_done !== 1'b1) begin err_count++; $display("FAIL gaps_wr_done got %b want 1", slave_tx_done); end
    cyc();
    do_read(12'h2C7, 4'd0, 40, 2);
    cmp_count++; if (rd_q.size() != 1 || rd_q[0] !== 8'h5A || !rd_done_seen) begin err_count++; $display("FAIL gaps_rd got n=%0d done=%0d want 5a", rd_q.size(), rd_done_seen); end
  endtask

  task automatic test_abort();
    bit done_seen;
    send_header(1'b0, 12'hFFE, 4'd1, 0);
    cyc();
    master_ready = 1;
    cyc(); cyc(); cyc();
    rx_done_in = 1;
    cyc();
    rx_done_in = 0; master_ready = 0;
    cmp_count++; if (slave_valid !== 1'b0 || slave_ready !== 1'b1 || slave_tx_done !== 1'b0) begin err_count++; $display("FAIL abort_rd got valid=%b ready=%b done=%b want 0 1 0", slave_valid, slave_ready, slave_tx_done); end
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin master_ready = 1'($urandom); cyc(); if (slave_tx_done) done_seen = 1; end
    master_ready = 0;
    cmp_count++; if (done_seen) begin err_count++; $display("FAIL abort_rd_nodone got done pulse want none"); end

    wr_q = '{8'hEE};
    do_write(12'h302, 4'd0, 0);
    cyc();
    send_header(1'b1, 12'h300, 4'd2, 0);
    send_word(8'h81, DW, 0); ref_mem[12'h300] = 8'h81;
    send_word(8'h42, DW, 0); ref_mem[12'h301] = 8'h42;
    send_word(8'h99, DW - 1, 0);
    master_valid = 1; rx_data = 1; rx_done_in = 1;
    cyc();
    master_valid = 0; rx_done_in = 0;
    cmp_count++; if (slave_ready !== 1'b1 || slave_tx_done !== 1'b0) begin err_count++; $display("FAIL abort_wr got ready=%b done=%b want 1 0", slave_ready, slave_tx_done); end
    cyc();
    do_read(12'h300, 4'd2, 0, 0);
    cmp_count++; if (rd_q.size() != 3 || rd_q[0] !== 8'h81 || rd_q[1] !== 8'h42 || rd_q[2] !== 8'hEE) begin err_count++; $display("FAIL abort_wr_commit got n=%0d w2=%h want 81 42 ee", rd_q.size(), (rd_q.size() > 2) ? rd_q[2] : 8'hxx); end
  endtask

  task automatic test_reset_mid();
    send_header(1'b1, 12'h100, 4'd1, 0);
    send_word(8'h3C, DW, 0); ref_mem[12'h100] = 8'h3C;
    send_word(8'hC3, 3, 0);
    reset = 1; master_valid = 1; rx_data = 1'($urandom); rx_done_in = 1;
    cyc();
    cmp_count++; if (slave_ready !== 1'b1 || slave_valid !== 1'b0 || tx_data !== 1'b0 || slave_tx_done !== 1'b0) begin err_count++; $display("FAIL midreset_out got %b%b%b%b want 1000", slave_ready, slave_valid, tx_data, slave_tx_done); end
    cyc();
    reset = 0; idle_inputs();
    cyc();
    cmp_count++; if (slave_ready !== 1'b1 || slave_tx_done !== 1'b0) begin err_count++; $display("FAIL midreset_idle got ready=%b done=%b want 1 0", slave_ready, slave_tx_done); end
    do_read(12'h100, 4'd0, 0, 0);
    cmp_count++; if (rd_q.size() != 1 || rd_q[0] !== 8'h3C) begin err_count++; $display("FAIL midreset_keep got n=%0d want 3c", rd_q.size()); end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    for (int t = 0; t < 8; t++) begin
      a = AW'($urandom);
      b = BW'($urandom_range(3));
      wr_q.delete();
      for (int w = 0; w <= int'(b); w++) wr_q.push_back(DW'($urandom));
      do_write(a, b, 20);
      cmp_count++; if (slave_tx_done !== 1'b1) begin err_count++; $display("FAIL rand%0d_wr_done got %b want 1", t, slave_tx_done); end
      cyc();
      do_read(a, b, 20, int'($urandom_range(2)));
      cmp_count++; if (rd_q.size() != int'(b) + 1 || !rd_done_seen || rd_held_bad != 0 || rd_invalid != int'(b) + 1) begin err_count++; $display("FAIL rand%0d_rd_shape got n=%0d done=%0d held_bad=%0d bubbles=%0d want n=%0d", t, rd_q.size(), rd_done_seen, rd_held_bad, rd_invalid, int'(b) + 1); end
      for (int w = 0; w < rd_q.size(); w++) begin
        cmp_count++;
        if (rd_q[w] !== ref_mem[AW'(int'(a) + w)]) begin err_count++; $display("FAIL rand%0d_word%0d got %h want %h", t, w, rd_q[w], ref_mem[AW'(int'(a) + w)]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_ready_stall();
    test_gaps_illegal();
    test_abort();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
